// File: rtl/iic_pkg.sv
// Shared types for the I2C responder register file: FSM states, ACK levels, bus event codes.
// Optional build macro used by this slice: IIC_GLITCH_FILTER_EN (see iic_line_sync).
package iic_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RACK,
        ST_WAIT_STOP
    } iic_state_t;

    localparam logic IIC_ACK  = 1'b0;
    localparam logic IIC_NACK = 1'b1;

    typedef enum logic [1:0] {
        EV_NONE  = 2'd0,
        EV_START = 2'd1,
        EV_STOP  = 2'd2
    } iic_event_t;

endpackage

// File: rtl/iic_line_sync.sv
// One bus line: 2-FF synchroniser, optional glitch filter (IIC_GLITCH_FILTER_EN), and
// registered level plus rise/fall pulses. Idle level of an I2C line is high.
module iic_line_sync (
    input  logic clk_50m,
    input  logic reset,
    input  logic line_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);
    logic sync1_q, sync1_d, sync2_q, sync2_d;
    logic level_q, level_d, rise_q, rise_d, fall_q, fall_d;
    logic clean;

    always_comb begin
        sync1_d = line_i;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk_50m) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

`ifdef IIC_GLITCH_FILTER_EN
    logic [2:0] maj_q, maj_d;
    logic       maj_bit;
    logic       filt_q, filt_d;
    logic [2:0] stab_cnt_q, stab_cnt_d;

    // Majority of three samples, then the result must disagree with the filtered
    // level for five consecutive cycles before the filtered level follows it.
    always_comb begin
        maj_d      = {maj_q[1:0], sync2_q};
        maj_bit    = (maj_q[0] & maj_q[1]) | (maj_q[1] & maj_q[2]) | (maj_q[0] & maj_q[2]);
        filt_d     = filt_q;
        stab_cnt_d = 3'd0;
        if (maj_bit != filt_q) begin
            if (stab_cnt_q == 3'd4) begin
                filt_d = maj_bit;
            end else begin
                stab_cnt_d = stab_cnt_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk_50m) begin
        if (reset) begin
            maj_q      <= 3'b111;
            filt_q     <= 1'b1;
            stab_cnt_q <= 3'd0;
        end else begin
            maj_q      <= maj_d;
            filt_q     <= filt_d;
            stab_cnt_q <= stab_cnt_d;
        end
    end

    assign clean = filt_q;
`else
    assign clean = sync2_q;
`endif

    always_comb begin
        level_d = clean;
        rise_d  = clean & ~level_q;
        fall_d  = ~clean & level_q;
    end

    always_ff @(posedge clk_50m) begin
        if (reset) begin
            level_q <= 1'b1;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/iic_slave_regs.sv
// I2C responder exposing NUM_REGS 8-bit registers with an auto-incrementing pointer.
// Build option: define IIC_GLITCH_FILTER_EN to add input glitch filtering in iic_line_sync.
module iic_slave_regs
    import iic_pkg::*;
#(
    parameter logic [6:0]            DEV_ADDR = 7'h3C,
    parameter int unsigned           NUM_REGS = 8,
    parameter logic [NUM_REGS*8-1:0] REG_INIT = '0
) (
    input  logic                        clk_50m,
    input  logic                        reset,
    input  logic                        scl_i,
    input  logic                        sda_i,
    output logic                        sda_o,
    output logic                        sda_t,
    output logic [NUM_REGS*8-1:0]       reg_q,
    output logic                        wr_stb,
    output logic [$clog2(NUM_REGS)-1:0] wr_addr,
    output logic                        busy
);
    localparam int unsigned AW = $clog2(NUM_REGS);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    iic_line_sync u_scl_sync (
        .clk_50m (clk_50m),
        .reset   (reset),
        .line_i  (scl_i),
        .level_o (scl_lvl),
        .rise_o  (scl_rise),
        .fall_o  (scl_fall)
    );

    iic_line_sync u_sda_sync (
        .clk_50m (clk_50m),
        .reset   (reset),
        .line_i  (sda_i),
        .level_o (sda_lvl),
        .rise_o  (sda_rise),
        .fall_o  (sda_fall)
    );

    iic_state_t    state_q, state_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic          sda_t_q, sda_t_d;
    logic          busy_q, busy_d;
    logic          wr_stb_q, wr_stb_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]    regs_q [NUM_REGS];
    logic [7:0]    regs_d [NUM_REGS];
    logic [7:0]    regs_init [NUM_REGS];

    iic_event_t bus_ev;
    logic [7:0] rx_byte;
    logic       wr_en;

    always_comb begin
        bus_ev = EV_NONE;
        if (scl_lvl && sda_fall) begin
            bus_ev = EV_START;
        end else if (scl_lvl && sda_rise) begin
            bus_ev = EV_STOP;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        ptr_d     = ptr_q;
        sda_t_d   = sda_t_q;
        busy_d    = busy_q;
        wr_en     = 1'b0;
        rx_byte   = {shift_q[6:0], sda_lvl};

        if (bus_ev == EV_START) begin
            state_d   = ST_ADDR;
            bit_cnt_d = 4'd0;
            shift_d   = 8'd0;
            sda_t_d   = 1'b1;
        end else if (bus_ev == EV_STOP) begin
            state_d = ST_IDLE;
            sda_t_d = 1'b1;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR, ST_PTR, ST_WDATA: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_d = 4'd0;
                            if (state_q == ST_ADDR) begin
                                if ((rx_byte[7:1] == DEV_ADDR) && (DEV_ADDR != 7'h00)) begin
                                    state_d = ST_ADDR_ACK;
                                    busy_d  = 1'b1;
                                end else begin
                                    state_d = ST_WAIT_STOP;
                                end
                            end else if (state_q == ST_PTR) begin
                                ptr_d   = rx_byte[AW-1:0];
                                state_d = ST_PTR_ACK;
                            end else begin
                                wr_en   = 1'b1;
                                ptr_d   = ptr_q + 1'b1;
                                state_d = ST_WDATA_ACK;
                            end
                        end
                    end
                end
                // First SCL fall pulls SDA low, the next one releases it and moves on.
                ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
                    if (scl_fall) begin
                        if (sda_t_q) begin
                            sda_t_d = IIC_ACK;
                        end else begin
                            sda_t_d = 1'b1;
                            if (state_q == ST_ADDR_ACK && shift_q[0]) begin
                                state_d = ST_RDATA;
                                shift_d = regs_q[ptr_q];
                                sda_t_d = regs_q[ptr_q][7];
                            end else if (state_q == ST_ADDR_ACK) begin
                                state_d = ST_PTR;
                            end else begin
                                state_d = ST_WDATA;
                            end
                        end
                    end
                end
                ST_RDATA: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            state_d   = ST_RACK;
                            sda_t_d   = 1'b1;
                            bit_cnt_d = 4'd0;
                            ptr_d     = ptr_q + 1'b1;
                        end else begin
                            shift_d = {shift_q[6:0], shift_q[7]};
                            sda_t_d = shift_q[6];
                        end
                    end
                end
                // bit_cnt 1 marks "master acknowledged"; the next byte loads on the following fall.
                ST_RACK: begin
                    if (scl_rise) begin
                        if (sda_lvl == IIC_NACK) begin
                            state_d = ST_WAIT_STOP;
                        end else begin
                            bit_cnt_d = 4'd1;
                        end
                    end else if (scl_fall && bit_cnt_q == 4'd1) begin
                        state_d   = ST_RDATA;
                        bit_cnt_d = 4'd0;
                        shift_d   = regs_q[ptr_q];
                        sda_t_d   = regs_q[ptr_q][7];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[ptr_q] = rx_byte;
        end
        wr_stb_d  = wr_en;
        wr_addr_d = wr_en ? ptr_q : wr_addr_q;
    end

    always_ff @(posedge clk_50m) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= 4'd0;
            shift_q   <= 8'd0;
            ptr_q     <= '0;
            sda_t_q   <= 1'b1;
            busy_q    <= 1'b0;
            wr_stb_q  <= 1'b0;
            wr_addr_q <= '0;
            regs_q    <= regs_init;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            ptr_q     <= ptr_d;
            sda_t_q   <= sda_t_d;
            busy_q    <= busy_d;
            wr_stb_q  <= wr_stb_d;
            wr_addr_q <= wr_addr_d;
            regs_q    <= regs_d;
        end
    end

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
        assign regs_init[gi]      = REG_INIT[8*gi +: 8];
        assign reg_q[8*gi +: 8]   = regs_q[gi];
    end

    assign sda_o   = 1'b0;
    assign sda_t   = sda_t_q;
    assign wr_stb  = wr_stb_q;
    assign wr_addr = wr_addr_q;
    assign busy    = busy_q;

endmodule
